// File: rtl/fsm_code_sender_pkg.sv
// fsm_code_sender_pkg: shared state encoding and counter width helper for fsm_code_sender
package fsm_code_sender_pkg;
   typedef enum logic [2:0] {IDLE, SEND, WAIT, GAP, DONE} state_t;
   function automatic int cw(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction
endpackage

// File: rtl/fsm_code_sender_hold_counter.sv
// hold_counter: loadable down-counter, tc_o high while the count is zero
module hold_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load_i,
   input  logic [W-1:0] val_i,
   input  logic         en_i,
   output logic         tc_o
);
   logic [W-1:0] cnt_q, cnt_d;
   always_comb cnt_d = load_i ? val_i : (en_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else cnt_q <= cnt_d;
   end
   assign tc_o = cnt_q == '0;
endmodule

// File: rtl/fsm_code_sender.sv
// fsm_code_sender: serialises a latched code word onto A MSB first, then waits for unlock.
// FSM_CODE_SENDER_RETRY_EN adds GAP plus up to MAX_RETRY resends after a timeout.
module fsm_code_sender
   import fsm_code_sender_pkg::*;
#(
   parameter int CODE_LEN   = 4,
   parameter int BIT_CYCLES = 2,
   parameter int TIMEOUT    = 8,
   parameter int MAX_RETRY  = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [CODE_LEN-1:0] code,
   input  logic                unlock,
   output logic                A,
   output logic                busy,
   output logic                done,
   output logic                success,
   output logic                fail
);
   localparam int TW = cw((BIT_CYCLES > TIMEOUT) ? BIT_CYCLES : TIMEOUT);
   localparam int BW = cw(CODE_LEN);
   localparam logic [TW-1:0] BIT_LD = TW'(BIT_CYCLES - 1);
   localparam logic [TW-1:0] TO_LD  = TW'(TIMEOUT - 1);
   localparam logic [BW-1:0] MSB    = BW'(CODE_LEN - 1);
   state_t state_q, state_d;
   logic [CODE_LEN-1:0] code_q, code_d;
   logic [BW-1:0] bit_q, bit_d;
   logic a_q, a_d, succ_q, succ_d, fail_q, fail_d;
   logic ld, tc;
   logic [TW-1:0] ld_val;
`ifdef FSM_CODE_SENDER_RETRY_EN
   localparam int RW = cw(MAX_RETRY);
   localparam logic [RW-1:0] MR = RW'(MAX_RETRY);
   logic [RW-1:0] retry_q, retry_d;
`endif
   hold_counter #(.W(TW)) u_hold (
      .clk   (clk),
      .reset (reset),
      .load_i(ld),
      .val_i (ld_val),
      .en_i  (1'b1),
      .tc_o  (tc)
   );
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         code_q  <= '0;
         bit_q   <= '0;
         a_q     <= 1'b0;
         succ_q  <= 1'b0;
         fail_q  <= 1'b0;
`ifdef FSM_CODE_SENDER_RETRY_EN
         retry_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         code_q  <= code_d;
         bit_q   <= bit_d;
         a_q     <= a_d;
         succ_q  <= succ_d;
         fail_q  <= fail_d;
`ifdef FSM_CODE_SENDER_RETRY_EN
         retry_q <= retry_d;
`endif
      end
   end
   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      bit_d   = bit_q;
      a_d     = a_q;
      succ_d  = succ_q;
      fail_d  = fail_q;
      ld      = 1'b0;
      ld_val  = BIT_LD;
`ifdef FSM_CODE_SENDER_RETRY_EN
      retry_d = retry_q;
`endif
      unique case (state_q)
         IDLE: if (start) begin
            state_d = SEND;
            code_d  = code;
            bit_d   = MSB;
            a_d     = code[CODE_LEN-1];
            succ_d  = 1'b0;
            fail_d  = 1'b0;
            ld      = 1'b1;
`ifdef FSM_CODE_SENDER_RETRY_EN
            retry_d = '0;
`endif
         end
         SEND: if (tc) begin
            ld = 1'b1;
            if (bit_q == '0) begin
               state_d = WAIT;
               a_d     = 1'b0;
               ld_val  = TO_LD;
            end else begin
               bit_d = bit_q - 1'b1;
               a_d   = code_q[bit_d];
            end
         end
         WAIT: if (unlock) begin
            state_d = DONE;
            succ_d  = 1'b1;
         end else if (tc) begin
`ifdef FSM_CODE_SENDER_RETRY_EN
            if (retry_q < MR) begin
               state_d = GAP;
               retry_d = retry_q + 1'b1;
               ld      = 1'b1;
            end else begin
               state_d = DONE;
               fail_d  = 1'b1;
            end
`else
            state_d = DONE;
            fail_d  = 1'b1;
`endif
         end
         GAP: if (tc) begin
            state_d = SEND;
            bit_d   = MSB;
            a_d     = code_q[CODE_LEN-1];
            ld      = 1'b1;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_comb begin
      busy    = state_q != IDLE;
      done    = state_q == DONE;
      A       = a_q;
      success = succ_q;
      fail    = fail_q;
   end
endmodule
